// File: rtl/rst_seq_gen.sv
// Reset sequencer for the SoC platform.
// Synchronises the two reset pushbuttons and the MMCM lock, debounces the
// combined button press, then walks a fixed sequence:
//   HOLD -> WAIT_LOCK -> PERIPH (peripheral reset held) -> SOC -> RUN.
// A debounced press forces HOLD from anywhere; losing lock forces WAIT_LOCK.
//
// Ports:
//   clk            single clock for all logic
//   rst_n          synchronous active-low block reset
//   btn_fpga_rst_n raw FPGA reset button (async, active-low)
//   btn_mcu_rst_n  raw MCU reset button (async, active-low)
//   mmcm_locked    MMCM lock (async, active-high)
//   periph_rst     peripheral reset, active-high, registered
//   soc_rst_n      SoC top-level reset, active-low, registered
//   seq_state      current state: HOLD=0 WAIT_LOCK=1 PERIPH=2 SOC=3 RUN=4
//   run_cnt        entries into RUN since rst_n, saturating at 255
module rst_seq_gen #(
  parameter int unsigned DEBOUNCE_CYC = 16000,
  parameter int unsigned PERIPH_DLY   = 16,
  parameter int unsigned SOC_DLY      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_fpga_rst_n,
  input  logic       btn_mcu_rst_n,
  input  logic       mmcm_locked,
  output logic       periph_rst,
  output logic       soc_rst_n,
  output logic [2:0] seq_state,
  output logic [7:0] run_cnt
);

  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StWaitLock = 3'd1,
    StPeriph   = 3'd2,
    StSoc      = 3'd3,
    StRun      = 3'd4
  } state_e;

  localparam logic [15:0] DbLast     = 16'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]  PeriphLast = 8'(PERIPH_DLY - 1);
  localparam logic [7:0]  SocLast    = 8'(SOC_DLY - 1);

  // Synchronizers
  logic r_btn_fpga_meta, r_btn_fpga_s;
  logic r_btn_mcu_meta, r_btn_mcu_s;
  logic r_locked_meta, r_locked_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btn_fpga_meta <= 1'b0;
      r_btn_fpga_s    <= 1'b0;
      r_btn_mcu_meta  <= 1'b0;
      r_btn_mcu_s     <= 1'b0;
      r_locked_meta   <= 1'b0;
      r_locked_s      <= 1'b0;
    end else begin
      r_btn_fpga_meta <= btn_fpga_rst_n;
      r_btn_fpga_s    <= r_btn_fpga_meta;
      r_btn_mcu_meta  <= btn_mcu_rst_n;
      r_btn_mcu_s     <= r_btn_mcu_meta;
      r_locked_meta   <= mmcm_locked;
      r_locked_s      <= r_locked_meta;
    end
  end

  // Debouncer
  logic        w_raw_press;
  logic        r_db_press, w_db_press_d;
  logic [15:0] r_db_cnt, w_db_cnt_d;

  assign w_raw_press = ~r_btn_fpga_s | ~r_btn_mcu_s;

  // The counter tracks consecutive disagreeing edges; the flip happens on
  // the edge that would be the DEBOUNCE_CYC-th disagreement.
  always_comb begin
    w_db_press_d = r_db_press;
    w_db_cnt_d   = '0;
    if (w_raw_press != r_db_press) begin
      if (r_db_cnt == DbLast) begin
        w_db_press_d = w_raw_press;
      end else begin
        w_db_cnt_d = r_db_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_db_press <= 1'b1;
      r_db_cnt   <= '0;
    end else begin
      r_db_press <= w_db_press_d;
      r_db_cnt   <= w_db_cnt_d;
    end
  end

  // Sequencer FSM
  state_e     r_state, w_state_d;
  logic [7:0] r_dly_cnt, w_dly_cnt_d;
  logic [7:0] r_run_cnt, w_run_cnt_d;
  logic       r_periph_rst, w_periph_rst_d;
  logic       r_soc_rst_n, w_soc_rst_n_d;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StHold:     if (!r_db_press) w_state_d = StWaitLock;
      StWaitLock: if (r_locked_s) w_state_d = StPeriph;
      StPeriph:   if (r_dly_cnt == PeriphLast) w_state_d = StSoc;
      StSoc:      if (r_dly_cnt == SocLast) w_state_d = StRun;
      StRun:      w_state_d = StRun;
      default:    w_state_d = StHold;
    endcase
    // Lock is irrelevant while the button holds the system in HOLD.
    if (r_state != StHold && !r_locked_s) w_state_d = StWaitLock;
    // A debounced press overrides everything else.
    if (r_db_press) w_state_d = StHold;
  end

  always_comb begin
    w_dly_cnt_d = '0;
    if (w_state_d == r_state && (r_state == StPeriph || r_state == StSoc)) begin
      w_dly_cnt_d = r_dly_cnt + 8'd1;
    end

    w_run_cnt_d = r_run_cnt;
    if (r_state == StSoc && w_state_d == StRun && r_run_cnt != 8'hFF) begin
      w_run_cnt_d = r_run_cnt + 8'd1;
    end

    // Decoded from the next state so the output flops move with the state.
    w_periph_rst_d = (w_state_d == StHold) || (w_state_d == StWaitLock) ||
                     (w_state_d == StPeriph);
    w_soc_rst_n_d  = (w_state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StHold;
      r_dly_cnt    <= '0;
      r_run_cnt    <= '0;
      r_periph_rst <= 1'b1;
      r_soc_rst_n  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_dly_cnt    <= w_dly_cnt_d;
      r_run_cnt    <= w_run_cnt_d;
      r_periph_rst <= w_periph_rst_d;
      r_soc_rst_n  <= w_soc_rst_n_d;
    end
  end

  assign periph_rst = r_periph_rst;
  assign soc_rst_n  = r_soc_rst_n;
  assign seq_state  = r_state;
  assign run_cnt    = r_run_cnt;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen with DEBOUNCE_CYC=4, PERIPH_DLY=3, SOC_DLY=2.
// One vector per clock: inputs driven on the falling edge, outputs sampled
// 1 time unit after the following rising edge.
module tb_rst_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_fpga_rst_n;
  logic       btn_mcu_rst_n;
  logic       mmcm_locked;
  logic       periph_rst;
  logic       soc_rst_n;
  logic [2:0] seq_state;
  logic [7:0] run_cnt;

  always #5 clk = ~clk;

  rst_seq_gen #(
    .DEBOUNCE_CYC(4),
    .PERIPH_DLY  (3),
    .SOC_DLY     (2)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_fpga_rst_n(btn_fpga_rst_n),
    .btn_mcu_rst_n (btn_mcu_rst_n),
    .mmcm_locked   (mmcm_locked),
    .periph_rst    (periph_rst),
    .soc_rst_n     (soc_rst_n),
    .seq_state     (seq_state),
    .run_cnt       (run_cnt)
  );

  typedef struct {
    logic       rst_n;
    logic       bf;
    logic       bm;
    logic       lk;
    logic [2:0] st;
    logic       prst;
    logic       soc;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add_vec(input logic r, input logic bf, input logic bm, input logic lk,
                         input int n, input logic [2:0] st, input logic prst,
                         input logic soc, input logic [7:0] cnt);
    vec_t v;
    v.rst_n = r; v.bf = bf; v.bm = bm; v.lk = lk;
    v.st = st; v.prst = prst; v.soc = soc; v.cnt = cnt;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {st,prst,soc,cnt}=%h required %h", name, got, exp);
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, exp);
  endtask

  function automatic logic [12:0] pack_out(input logic [2:0] st, input logic prst,
                                           input logic soc, input logic [7:0] cnt);
    return {st, prst, soc, cnt};
  endfunction

  // Clocks along with the current inputs until seq_state hits target.
  task automatic wait_state(input logic [2:0] target, input int limit, input string name);
    bit hit = 1'b0;
    for (int k = 0; k < limit && !hit; k++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
      if (seq_state == target) hit = 1'b1;
    end
    n_checks++;
    if (hit) n_pass++;
    else $display("FAIL %s: seq_state=%0d never reached %0d in %0d cycles",
                  name, seq_state, target, limit);
  endtask

  initial begin
    rst_n = 1'b0; btn_fpga_rst_n = 1'b1; btn_mcu_rst_n = 1'b1; mmcm_locked = 1'b1;

    // Power-up
    add_vec(0, 1, 1, 1, 2, 0, 1, 0, 0);
    add_vec(1, 1, 1, 1, 6, 0, 1, 0, 0);
    add_vec(1, 1, 1, 1, 1, 1, 1, 0, 0);
    add_vec(1, 1, 1, 1, 3, 2, 1, 0, 0);
    add_vec(1, 1, 1, 1, 2, 3, 0, 0, 0);
    add_vec(1, 1, 1, 1, 2, 4, 0, 1, 1);
    // Lock loss in RUN, then relock and replay
    add_vec(1, 1, 1, 0, 2, 4, 0, 1, 1);
    add_vec(1, 1, 1, 0, 1, 1, 1, 0, 1);
    add_vec(1, 1, 1, 1, 2, 1, 1, 0, 1);
    add_vec(1, 1, 1, 1, 3, 2, 1, 0, 1);
    add_vec(1, 1, 1, 1, 2, 3, 0, 0, 1);
    add_vec(1, 1, 1, 1, 2, 4, 0, 1, 2);
    // 3-cycle MCU button glitch is rejected
    add_vec(1, 1, 0, 1, 3, 4, 0, 1, 2);
    add_vec(1, 1, 1, 1, 6, 4, 0, 1, 2);
    // Held FPGA button: HOLD at edge 7
    add_vec(1, 0, 1, 1, 6, 4, 0, 1, 2);
    add_vec(1, 0, 1, 1, 3, 0, 1, 0, 2);
    // Release replays power-up timing
    add_vec(1, 1, 1, 1, 6, 0, 1, 0, 2);
    add_vec(1, 1, 1, 1, 1, 1, 1, 0, 2);
    add_vec(1, 1, 1, 1, 3, 2, 1, 0, 2);
    add_vec(1, 1, 1, 1, 2, 3, 0, 0, 2);
    add_vec(1, 1, 1, 1, 2, 4, 0, 1, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n          = vecs[i].rst_n;
      btn_fpga_rst_n = vecs[i].bf;
      btn_mcu_rst_n  = vecs[i].bm;
      mmcm_locked    = vecs[i].lk;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), pack_out(seq_state, periph_rst, soc_rst_n, run_cnt),
            pack_out(vecs[i].st, vecs[i].prst, vecs[i].soc, vecs[i].cnt));
    end

    // Reset asserted mid-PERIPH clears everything on that edge
    @(negedge clk);
    mmcm_locked = 1'b0;
    wait_state(3'd1, 10, "mid_drop");
    @(negedge clk);
    mmcm_locked = 1'b1;
    wait_state(3'd2, 10, "mid_periph");
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_periph", pack_out(seq_state, periph_rst, soc_rst_n, run_cnt),
          pack_out(3'd0, 1'b1, 1'b0, 8'd0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_hold", pack_out(seq_state, periph_rst, soc_rst_n, run_cnt),
          pack_out(3'd0, 1'b1, 1'b0, 8'd0));
    wait_state(3'd4, 40, "post_rst_run");
    check("post_rst_run_out", pack_out(seq_state, periph_rst, soc_rst_n, run_cnt),
          pack_out(3'd4, 1'b0, 1'b1, 8'd1));

    // Saturation over 260 lock-drop/relock rounds
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      mmcm_locked = 1'b0;
      wait_state(3'd1, 10, $sformatf("sat_drop%0d", k));
      @(negedge clk);
      mmcm_locked = 1'b1;
      wait_state(3'd4, 20, $sformatf("sat_run%0d", k));
      if (k == 100) check8("run_cnt_k100", run_cnt, 8'd101);
      if (k == 254) check8("run_cnt_k254", run_cnt, 8'd255);
    end
    check8("run_cnt_sat", run_cnt, 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_gen.md
RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 16000; consecutive stable cycles needed for the debounced button state to change (1 ms at 16 MHz); range 1..65535.
REQ-002 Parameter PERIPH_DLY, default 16; cycles periph_rst stays high after entering PERIPH; range 1..255.
REQ-003 Parameter SOC_DLY, default 16; cycles between periph_rst release and soc_rst_n release; range 1..255.
REQ-004 clk  input  1  single clock for all logic (the 16 MHz MMCM output).
REQ-005 rst_n  input  1  block reset; synchronous, active-low.
REQ-006 btn_fpga_rst_n  input  1  raw FPGA reset pushbutton, asynchronous, active-low.
REQ-007 btn_mcu_rst_n  input  1  raw MCU reset pushbutton, asynchronous, active-low.
REQ-008 mmcm_locked  input  1  MMCM lock, asynchronous, active-high.
REQ-009 periph_rst  output  1  peripheral reset, active-high, registered.
REQ-010 soc_rst_n  output  1  SoC top-level reset (drives io_pads_aon_erst_n_i_ival), active-low, registered.
REQ-011 seq_state  output  3  current FSM state: HOLD=0, WAIT_LOCK=1, PERIPH=2, SOC=3, RUN=4.
REQ-012 run_cnt  output  8  number of entries into RUN since rst_n, saturating at 255.

Function
REQ-013 Each asynchronous input SHALL pass through its own 2-flop synchronizer; the synchronized value is valid after the 2nd clk edge.
REQ-014 raw_press SHALL be ~btn_fpga_s | ~btn_mcu_s, computed from synchronized values.
REQ-015 Debouncer: db_press SHALL change only after raw_press differs from db_press on DEBOUNCE_CYC consecutive edges; db_press flips on the edge where the count reaches DEBOUNCE_CYC-1; the counter clears on any edge where raw_press equals db_press.
REQ-016 mmcm_locked SHALL NOT be debounced; locked_s low acts on the next edge.
REQ-017 HOLD: stay while db_press=1; go to WAIT_LOCK when db_press=0.
REQ-018 WAIT_LOCK: go to PERIPH when locked_s=1, with a minimum of one cycle spent in WAIT_LOCK.
REQ-019 PERIPH: the counter clears on entry and increments each cycle; go to SOC on the edge where the count equals PERIPH_DLY-1.
REQ-020 SOC: the counter clears on entry; go to RUN on the edge where the count equals SOC_DLY-1.
REQ-021 RUN: stay indefinitely absent the events in REQ-022/023.
REQ-022 From any state, db_press=1 SHALL force HOLD on the next edge; this has the highest priority.
REQ-023 From WAIT_LOCK..RUN, locked_s=0 with db_press=0 SHALL force WAIT_LOCK on the next edge; lock is ignored in HOLD.
REQ-024 Output registers SHALL load from the next state, so the outputs change on the same edge as the state:
- periph_rst=1 in HOLD, WAIT_LOCK and PERIPH; 0 in SOC and RUN.
- soc_rst_n=1 only in RUN.
REQ-025 Outputs SHALL be glitch-free: driven directly from flops, with no combinational decode after the flops.
REQ-026 run_cnt SHALL increment on each SOC->RUN transition and hold at 255.

Reset
REQ-027 While rst_n=0 at an edge, the following SHALL hold:
- state=HOLD, periph_rst=1, soc_rst_n=0, run_cnt=0.
- Synchronizer flops=0, db_press=1, counters=0.
REQ-028 rst_n asserted in any state, including mid-PERIPH or mid-SOC, SHALL apply REQ-027 on that edge with no partial sequence retained.

Verification (DEBOUNCE_CYC=4, PERIPH_DLY=3, SOC_DLY=2; edges counted after the stated event)
REQ-029 Power-up:
- Stimulus: rst_n low 2 cycles then high; buttons=1, locked=1.
- Response: HOLD->WAIT_LOCK at edge 7; PERIPH at edge 8; periph_rst falls at edge 11; soc_rst_n rises at edge 13; run_cnt=1.
REQ-030 Lock loss in RUN:
- Stimulus: locked falls.
- Response: periph_rst=1, soc_rst_n=0, seq_state=1 at edge 3; after locked returns, the full PERIPH/SOC sequence replays and run_cnt=2.
REQ-031 Glitch rejection in RUN:
- Stimulus: btn_mcu_rst_n low for 3 cycles.
- Response: no output change, seq_state stays 4.
REQ-032 Held button in RUN:
- Stimulus: btn_fpga_rst_n low and held.
- Response: HOLD with both resets asserted at edge 7 (2 sync + 4 debounce + 1); release replays the REQ-029 timing.
REQ-033 Reset mid-sequence:
- Stimulus: rst_n low for 1 cycle while in PERIPH.
- Response: on that edge seq_state=0, periph_rst=1, soc_rst_n=0, run_cnt=0.
REQ-034 Saturation:
- Stimulus: 260 lock-drop/relock cycles.
- Response: run_cnt=255, with no wrap to 0.
